// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: display scheduler between the AHT10 sensor datapath and
// the 6-digit 7-segment scan driver. Latches temperature/humidity (x10
// fixed point), alternates a temperature and a humidity page on a timer,
// converts the shown value to BCD with a sequential double-dabble engine
// and writes a 24-bit nibble word (digit5 in [23:20] .. digit0 in [3:0]).
// A sensor timeout replaces the page with an error pattern.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active-high
//   data_vld  one-cycle strobe, temp_x10/humi_x10 valid
//   temp_x10  temperature x10, unsigned, clamped to 999
//   humi_x10  relative humidity x10, unsigned, clamped to 999
//   disp_din  nibble codes to the scan driver (A/B marker, C error, E blank)
//   disp_upd  one-cycle pulse when disp_din is rewritten
//   page      0 = temperature page, 1 = humidity page
//   err       sensor timeout active
//
// PAGE_CYCLES and TIMEOUT_CYCLES must both be at least 2.
module seg_disp_ctrl #(
  parameter int unsigned PAGE_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_vld,
  input  logic [9:0]  temp_x10,
  input  logic [9:0]  humi_x10,
  output logic [23:0] disp_din,
  output logic        disp_upd,
  output logic        page,
  output logic        err
);

  localparam int unsigned VAL_W  = 10;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned SH_W   = BCD_W + VAL_W;
  localparam int unsigned DIN_W  = 24;
  localparam int unsigned ITER_W = 4;
  localparam int unsigned PTMR_W = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [VAL_W-1:0]  VAL_MAX   = VAL_W'(999);
  localparam logic [PTMR_W-1:0] PTMR_MAX  = PTMR_W'(PAGE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_PRE   = TMO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(VAL_W - 1);

  localparam logic [3:0] CODE_TEMP  = 4'hA;
  localparam logic [3:0] CODE_HUMI  = 4'hB;
  localparam logic [3:0] CODE_ERR   = 4'hC;
  localparam logic [3:0] CODE_BLANK = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_UPDATE,
    S_ERRWR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [VAL_W-1:0]    r_temp;
  logic [VAL_W-1:0]    r_humi;
  logic                r_have_data;
  logic                r_pending;
  logic                r_err_pend;
  logic                r_err;
  logic                r_page;
  logic [PTMR_W-1:0]   r_ptmr;
  logic [TMO_W-1:0]    r_tmo;
  logic [SH_W-1:0]     r_shift;
  logic [ITER_W-1:0]   r_iter;
  logic                r_cpage;
  logic [DIN_W-1:0]    r_disp_din;
  logic                r_disp_upd;

  logic                w_load;
  logic                w_conv;
  logic                w_wr_page;
  logic                w_wr_err;
  logic                w_pend_clr;
  logic                w_page_tick;
  logic                w_tmo_hit;
  logic [VAL_W-1:0]    w_temp_cl;
  logic [VAL_W-1:0]    w_humi_cl;
  logic [SH_W-1:0]     w_adj;
  logic [3:0]          w_hund;
  logic [DIN_W-1:0]    w_page_word;

  assign disp_din = r_disp_din;
  assign disp_upd = r_disp_upd;
  assign page     = r_page;
  assign err      = r_err;

  // Input clamping to the 3-digit display range
  assign w_temp_cl = (temp_x10 > VAL_MAX) ? VAL_MAX : temp_x10;
  assign w_humi_cl = (humi_x10 > VAL_MAX) ? VAL_MAX : humi_x10;

  // Page timer only runs once data exists and no timeout is flagged
  assign w_page_tick = r_have_data && !r_err && (r_ptmr == PTMR_MAX);
  // Timeout counter is about to reach its saturation value this edge
  assign w_tmo_hit   = !data_vld && (r_tmo == TMO_PRE);

  // Double-dabble add-3 step on hundreds/tens/ones nibbles
  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < 3; i++) begin
      if (r_shift[VAL_W + 4*i +: 4] >= 4'd5) begin
        w_adj[VAL_W + 4*i +: 4] = r_shift[VAL_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Page word: marker, blank, hundreds (blanked when zero), tens, ones, blank
  assign w_hund      = r_shift[SH_W-1 -: 4];
  assign w_page_word = {r_cpage ? CODE_HUMI : CODE_TEMP,
                        CODE_BLANK,
                        (w_hund == 4'd0) ? CODE_BLANK : w_hund,
                        r_shift[SH_W-5 -: 4],
                        r_shift[SH_W-9 -: 4],
                        CODE_BLANK};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath strobes; error handling preempts conversions
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_conv      = 1'b0;
    w_wr_page   = 1'b0;
    w_wr_err    = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_err_pend) begin
          w_state_nxt = S_ERRWR;
        end else if (r_pending && !r_err) begin
          w_state_nxt = S_LOAD;
          w_pend_clr  = 1'b1;
        end
      end
      S_LOAD: begin
        if (r_err) begin
          w_state_nxt = S_ERRWR;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (r_err) begin
          w_state_nxt = S_ERRWR;
        end else begin
          w_conv = 1'b1;
          if (r_iter == ITER_LAST) begin
            w_state_nxt = S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        w_wr_page   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERRWR: begin
        w_wr_err    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture, timers, flags, BCD engine and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_temp      <= '0;
      r_humi      <= '0;
      r_have_data <= 1'b0;
      r_pending   <= 1'b0;
      r_err_pend  <= 1'b0;
      r_err       <= 1'b0;
      r_page      <= 1'b0;
      r_ptmr      <= '0;
      r_tmo       <= '0;
      r_shift     <= '0;
      r_iter      <= '0;
      r_cpage     <= 1'b0;
      r_disp_din  <= {6{CODE_BLANK}};
      r_disp_upd  <= 1'b0;
    end else begin
      r_disp_upd <= 1'b0;

      if (data_vld) begin
        r_temp      <= w_temp_cl;
        r_humi      <= w_humi_cl;
        r_have_data <= 1'b1;
        r_tmo       <= '0;
        r_err       <= 1'b0;
      end else begin
        if (r_tmo != TMO_MAX) begin
          r_tmo <= r_tmo + TMO_W'(1);
        end
        if (w_tmo_hit) begin
          r_err <= 1'b1;
        end
      end

      if (r_have_data && !r_err) begin
        if (w_page_tick) begin
          r_ptmr <= '0;
          r_page <= ~r_page;
        end else begin
          r_ptmr <= r_ptmr + PTMR_W'(1);
        end
      end

      // New data or a page flip always re-requests a conversion
      if (data_vld || w_page_tick) begin
        r_pending <= 1'b1;
      end else if (w_pend_clr) begin
        r_pending <= 1'b0;
      end

      if (w_tmo_hit) begin
        r_err_pend <= 1'b1;
      end else if (data_vld || w_wr_err) begin
        r_err_pend <= 1'b0;
      end

      if (w_load) begin
        r_shift <= {{BCD_W{1'b0}}, r_page ? r_humi : r_temp};
        r_cpage <= r_page;
        r_iter  <= '0;
      end

      if (w_conv) begin
        r_shift <= SH_W'({w_adj, 1'b0});
        r_iter  <= r_iter + ITER_W'(1);
      end

      if (w_wr_page) begin
        r_disp_din <= w_page_word;
        r_disp_upd <= 1'b1;
      end

      if (w_wr_err) begin
        r_disp_din <= {6{CODE_ERR}};
        r_disp_upd <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Testbench for seg_disp_ctrl: table-driven page vectors, directed
// multi-cycle corner cases, and randomized traffic against a reference model.
module tb_seg_disp_ctrl;

  localparam int unsigned P = 20;
  localparam int unsigned T = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_vld = 1'b0;
  logic [9:0]  temp_x10 = '0;
  logic [9:0]  humi_x10 = '0;
  logic [23:0] disp_din;
  logic        disp_upd;
  logic        page;
  logic        err;

  seg_disp_ctrl #(.PAGE_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_vld (data_vld),
    .temp_x10 (temp_x10),
    .humi_x10 (humi_x10),
    .disp_din (disp_din),
    .disp_upd (disp_upd),
    .page     (page),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Reference model state (spec-level quantities)
  int          m_temp, m_humi, m_ptmr, m_tmo, m_busy, m_snap_val;
  bit          m_have, m_pend, m_epend, m_err, m_page, m_errw, m_snap_pg;
  logic [23:0] m_din;
  bit          m_upd;

  function automatic logic [23:0] fmt(input bit pg, input int v);
    int h, t, o;
    logic [3:0] hn;
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    hn = (h == 0) ? 4'hE : 4'(h);
    return {pg ? 4'hB : 4'hA, 4'hE, hn, 4'(t), 4'(o), 4'hE};
  endfunction

  function automatic int clamp(input int x);
    return (x > 999) ? 999 : x;
  endfunction

  // One clock edge of the model. m_busy counts edges left in a conversion:
  // 12 = operand latch, 11..2 = ten shift steps, 1 = write.
  task automatic model_step();
    bit tick, hit, pend_clr, ep_clr;
    if (rst) begin
      m_din = 24'hEEEEEE; m_upd = 0; m_page = 0; m_err = 0;
      m_have = 0; m_pend = 0; m_epend = 0; m_ptmr = 0; m_tmo = 0;
      m_busy = 0; m_errw = 0; m_temp = 0; m_humi = 0;
      return;
    end
    m_upd = 0; pend_clr = 0; ep_clr = 0;
    if (m_errw) begin
      m_din = 24'hCCCCCC; m_upd = 1; m_errw = 0; ep_clr = 1;
    end else if (m_busy == 1) begin
      m_din = fmt(m_snap_pg, m_snap_val); m_upd = 1; m_busy = 0;
    end else if (m_busy >= 2) begin
      if (m_err) begin
        m_busy = 0; m_errw = 1;
      end else begin
        if (m_busy == 12) begin
          m_snap_pg  = m_page;
          m_snap_val = m_page ? m_humi : m_temp;
        end
        m_busy = m_busy - 1;
      end
    end else begin
      if (m_epend) m_errw = 1;
      else if (m_pend && !m_err) begin m_busy = 12; pend_clr = 1; end
    end

    tick = m_have && !m_err && (m_ptmr == int'(P) - 1);
    if (m_have && !m_err) m_ptmr = tick ? 0 : m_ptmr + 1;
    if (tick) m_page = !m_page;

    hit = !data_vld && (m_tmo == int'(T) - 2);
    if (data_vld) begin
      m_temp = clamp(int'(temp_x10)); m_humi = clamp(int'(humi_x10));
      m_have = 1; m_tmo = 0; m_err = 0;
    end else if (m_tmo < int'(T) - 1) begin
      m_tmo = m_tmo + 1;
    end
    if (hit) m_err = 1;

    if (data_vld || tick) m_pend = 1;
    else if (pend_clr) m_pend = 0;
    if (hit) m_epend = 1;
    else if (data_vld || ep_clr) m_epend = 0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset(output int rc);
    @(negedge clk);
    rst = 1; data_vld = 0;
    @(posedge clk); #1;
    rc = cyc;
    check("rst_din", 32'(disp_din), 32'h00EEEEEE);
    check("rst_upd", 32'(disp_upd), 32'd0);
    check("rst_page", 32'(page), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic send_data(input logic [9:0] t, input logic [9:0] h, output int t0);
    @(negedge clk);
    data_vld = 1; temp_x10 = t; humi_x10 = h;
    @(posedge clk); #1;
    t0 = cyc;
    @(negedge clk);
    data_vld = 0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_upd(input int exp_cyc, input logic [23:0] exp_din,
                            input bit exp_pg, input bit exp_err, input string name);
    bit found;
    found = 0;
    while (!found && cyc < exp_cyc + 4) begin
      @(posedge clk); #1;
      if (disp_upd) found = 1;
    end
    if (!found) begin
      check({name, "_seen"}, 32'd0, 32'd1);
    end else begin
      check({name, "_cyc"}, 32'(cyc), 32'(exp_cyc));
      check({name, "_din"}, 32'(disp_din), 32'(exp_din));
      check({name, "_page"}, 32'(page), 32'(exp_pg));
      check({name, "_err"}, 32'(err), 32'(exp_err));
      @(posedge clk); #1;
      check({name, "_pulse"}, 32'(disp_upd), 32'd0);
    end
  endtask

  task automatic expect_quiet(input int n, input string name);
    bit seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (disp_upd) seen = 1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  typedef struct {
    logic [9:0]  t;
    logic [9:0]  h;
    logic [23:0] exp_a;
    logic [23:0] exp_b;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int rc, t0, t1;
    vecs[0] = '{10'd253,  10'd618,  24'hAE253E, 24'hBE618E};
    vecs[1] = '{10'd7,    10'd1023, 24'hAEE07E, 24'hBE999E};
    vecs[2] = '{10'd1023, 10'd5,    24'hAE999E, 24'hBEE05E};
    vecs[3] = '{10'd0,    10'd999,  24'hAEE00E, 24'hBE999E};
    vecs[4] = '{10'd100,  10'd40,   24'hAE100E, 24'hBEE40E};

    // Page vectors: temp page, humidity page after one toggle, then the
    // timeout lands mid-conversion of the next temp page and aborts it.
    for (int i = 0; i < 5; i++) begin
      do_reset(rc);
      send_data(vecs[i].t, vecs[i].h, t0);
      check("cap_err", 32'(err), 32'd0);
      expect_upd(t0 + 13, vecs[i].exp_a, 1'b0, 1'b0, $sformatf("v%0d_temp", i));
      expect_upd(t0 + 33, vecs[i].exp_b, 1'b1, 1'b0, $sformatf("v%0d_humi", i));
      expect_upd(t0 + 51, 24'hCCCCCC, 1'b0, 1'b1, $sformatf("v%0d_abort", i));
    end

    // New data during the 5th shift step: old value, new value, then the
    // page toggle that happened during the second conversion.
    do_reset(rc);
    send_data(10'd253, 10'd618, t0);
    wait_until(t0 + 6);
    send_data(10'd444, 10'd618, t1);
    check("mid_dv_edge", 32'(t1), 32'(t0 + 7));
    expect_upd(t0 + 13, 24'hAE253E, 1'b0, 1'b0, "mid_old");
    expect_upd(t0 + 26, 24'hAE444E, 1'b1, 1'b0, "mid_new");
    expect_upd(t0 + 39, 24'hBE618E, 1'b1, 1'b0, "mid_toggle");

    // Timeout with no sensor, single error write, then recovery
    do_reset(rc);
    wait_until(rc + 48);
    check("tmo_pre", 32'(err), 32'd0);
    @(posedge clk); #1;
    check("tmo_hit", 32'(err), 32'd1);
    expect_upd(rc + 51, 24'hCCCCCC, 1'b0, 1'b1, "tmo_errwr");
    expect_quiet(30, "tmo_single");
    check("tmo_hold", 32'(err), 32'd1);
    send_data(10'd321, 10'd456, t0);
    check("rec_err", 32'(err), 32'd0);
    expect_upd(t0 + 13, 24'hAE321E, 1'b0, 1'b0, "rec_page");

    // Reset in the middle of a conversion leaves no stale update
    do_reset(rc);
    send_data(10'd253, 10'd618, t0);
    wait_until(t0 + 6);
    do_reset(rc);
    expect_quiet(25, "rst_nostale");

    // Randomized traffic against the model, including timeouts and resets
    do_reset(rc);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 599) == 0);
      data_vld = ($urandom_range(0, (i < 2000) ? 19 : 69) == 0);
      temp_x10 = 10'($urandom_range(0, 1023));
      humi_x10 = 10'($urandom_range(0, 1023));
      @(posedge clk); #1;
      check("rand", {5'd0, disp_din, disp_upd, page, err},
                    {5'd0, m_din, m_upd, m_page, m_err});
    end
    @(negedge clk);
    rst = 0; data_vld = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
